// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard control for the RV32I 5-stage pipeline.
// Results that have reached WB come through register-file write-through, so only EX and MEM entries are kept.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_EX  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // EX-stage entry (p0) and MEM-stage entry (p1)
  logic              vld_p0;
  logic [REG_AW-1:0] rd_p0;
  logic              we_p0;
  logic              ld_p0;
  logic              vld_p1;
  logic [REG_AW-1:0] rd_p1;
  logic              we_p1;

  logic       ex_prod;
  logic       mem_prod;
  logic       load_use;
  logic       bubble;
  logic [1:0] sel_a_nxt;
  logic [1:0] sel_b_nxt;

  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic ex_hit,
                                         input logic mem_hit);
    if (!use_rs)      return SEL_RF;
    else if (ex_hit)  return SEL_EX;
    else if (mem_hit) return SEL_MEM;
    else              return SEL_RF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  assign ex_prod  = vld_p0 & we_p0 & (rd_p0 != '0);
  assign mem_prod = vld_p1 & we_p1 & (rd_p1 != '0);

  // A load in EX is never a forwarding source; it forces the load-use stall instead.
  assign sel_a_nxt = fwd_sel(id_use_rs1,
                             ex_prod & ~ld_p0 & (rd_p0 == id_rs1),
                             mem_prod & (rd_p1 == id_rs1));
  assign sel_b_nxt = fwd_sel(id_use_rs2,
                             ex_prod & ~ld_p0 & (rd_p0 == id_rs2),
                             mem_prod & (rd_p1 == id_rs2));

  assign load_use = id_valid & ex_prod & ld_p0 &
                    ((id_use_rs1 & (rd_p0 == id_rs1)) | (id_use_rs2 & (rd_p0 == id_rs2)));
  assign stall    = load_use & ~flush & ~pipe_hold;
  assign bubble   = flush | stall | ~id_valid;

  // ID -> EX -> MEM control and registered selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      fwd_a_sel   <= SEL_RF;
      fwd_b_sel   <= SEL_RF;
      stall_count <= '0;
    end else if (!pipe_hold) begin
      vld_p1    <= vld_p0;
      vld_p0    <= ~bubble;
      fwd_a_sel <= bubble ? SEL_RF : sel_a_nxt;
      fwd_b_sel <= bubble ? SEL_RF : sel_b_nxt;
      if (stall) stall_count <= sat_inc(stall_count);
    end
  end

  // Entry payload is qualified by vld_pN, so it carries no reset
  always_ff @(posedge clk) begin
    if (!pipe_hold) begin
      rd_p1 <= rd_p0;
      we_p1 <= we_p0;
      rd_p0 <= id_rd;
      we_p0 <= id_reg_write;
      ld_p0 <= id_mem_read;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed table-driven bench for fwd_hazard_ctrl plus reset and counter-saturation sequences.
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pipe_hold;
  logic       flush;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall;
  logic [3:0] stall_count;

  int checks = 0;
  int errors = 0;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_hold    (pipe_hold),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       hold;
    logic       flush;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       es;
    logic [1:0] ea;
    logic [1:0] eb;
    int         ec;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(int h, int f, int v, int rs1, int rs2, int u1, int u2,
                              int rd, int we, int ld, int es, int ea, int eb, int ec);
    vec_t r;
    r.hold = 1'(h);   r.flush = 1'(f);  r.v  = 1'(v);
    r.rs1  = 5'(rs1); r.rs2   = 5'(rs2);
    r.u1   = 1'(u1);  r.u2    = 1'(u2);
    r.rd   = 5'(rd);  r.we    = 1'(we); r.ld = 1'(ld);
    r.es   = 1'(es);  r.ea    = 2'(ea); r.eb = 2'(eb);
    r.ec   = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pipe_hold    = v.hold;
    flush        = v.flush;
    id_valid     = v.v;
    id_rs1       = v.rs1;
    id_rs2       = v.rs2;
    id_use_rs1   = v.u1;
    id_use_rs2   = v.u2;
    id_rd        = v.rd;
    id_reg_write = v.we;
    id_mem_read  = v.ld;
  endtask

  // Drive one ID cycle: stall checked mid-cycle, registered outputs just after the edge.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    chk($sformatf("%s stall", tag), int'(stall), int'(v.es));
    @(posedge clk);
    #1;
    chk($sformatf("%s fwd_a", tag), int'(fwd_a_sel), int'(v.ea));
    chk($sformatf("%s fwd_b", tag), int'(fwd_b_sel), int'(v.eb));
    chk($sformatf("%s count", tag), int'(stall_count), v.ec);
  endtask

  initial begin
    vec_t cons;
    int   ec;

    // add x5 -> dependent consumer
    tbl[0]  = mk(0,0,1,  1, 2,1,1,  5,1,0, 0,0,0,0);
    tbl[1]  = mk(0,0,1,  5, 3,1,1,  8,1,0, 0,2,0,0);
    // add x6, nop, sub rs2=x6 ; then x6 written by both EX and MEM
    tbl[2]  = mk(0,0,1,  1, 1,1,1,  6,1,0, 0,0,0,0);
    tbl[3]  = mk(0,0,0,  0, 0,0,0,  0,0,0, 0,0,0,0);
    tbl[4]  = mk(0,0,1,  1, 6,1,1,  9,1,0, 0,0,1,0);
    tbl[5]  = mk(0,0,1,  2, 3,1,1,  6,1,0, 0,0,0,0);
    tbl[6]  = mk(0,0,1,  6, 2,1,1,  6,1,0, 0,2,0,0);
    tbl[7]  = mk(0,0,1,  3, 6,1,1, 10,1,0, 0,0,2,0);
    // lw x7 then add rs1=x7: one stall then MEM forward
    tbl[8]  = mk(0,0,1,  2, 0,1,0,  7,1,1, 0,0,0,0);
    tbl[9]  = mk(0,0,1,  7, 1,1,1, 11,1,0, 1,0,0,1);
    tbl[10] = mk(0,0,1,  7, 1,1,1, 11,1,0, 0,1,0,1);
    // unused rs2 matching a load; x0 producers
    tbl[11] = mk(0,0,1,  1, 0,1,0,  7,1,1, 0,0,0,1);
    tbl[12] = mk(0,0,1,  1, 7,1,0, 12,1,0, 0,0,0,1);
    tbl[13] = mk(0,0,1,  1, 7,1,0,  0,1,0, 0,0,0,1);
    tbl[14] = mk(0,0,1,  0, 0,1,1, 13,1,0, 0,0,0,1);
    tbl[15] = mk(0,0,1,  0, 0,1,1, 14,1,0, 0,0,0,1);
    // flush beats load-use
    tbl[16] = mk(0,0,1,  1, 0,1,0,  7,1,1, 0,0,0,1);
    tbl[17] = mk(0,1,1,  7,14,1,1, 15,1,0, 0,0,0,1);
    tbl[18] = mk(0,0,1,  7, 2,1,1, 16,1,0, 0,1,0,1);
    // pipe_hold for 3 cycles with a load-use pending (flush ignored while held)
    tbl[19] = mk(0,0,1, 16, 0,1,0,  8,1,1, 0,2,0,1);
    tbl[20] = mk(1,0,1,  8,16,1,1, 17,1,0, 0,2,0,1);
    tbl[21] = mk(1,1,1,  8,16,1,1, 17,1,0, 0,2,0,1);
    tbl[22] = mk(1,0,1,  8,16,1,1, 17,1,0, 0,2,0,1);
    tbl[23] = mk(0,0,1,  8,16,1,1, 17,1,0, 1,0,0,2);
    tbl[24] = mk(0,0,1,  8,16,1,1, 17,1,0, 0,1,0,2);

    rst_n = 1'b0;
    drive(mk(0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0));
    #12;
    chk("reset stall", int'(stall), 0);
    chk("reset fwd_a", int'(fwd_a_sel), 0);
    chk("reset fwd_b", int'(fwd_b_sel), 0);
    chk("reset count", int'(stall_count), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset with a forward and a stall pending
    apply(mk(0,0,1, 17,0,1,0, 7,1,1, 0,2,0,2), "pre_rst lw");
    cons = mk(0,0,1, 7,0,1,0, 11,1,0, 0,0,0,0);
    drive(cons);
    #1;
    chk("pre_rst stall", int'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst stall", int'(stall), 0);
    chk("async_rst fwd_a", int'(fwd_a_sel), 0);
    chk("async_rst count", int'(stall_count), 0);
    #1;
    rst_n = 1'b1;
    apply(cons, "post_rst");

    // Counter saturation: 17 load-use stalls into a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      ec = (i < 15) ? i : 15;
      apply(mk(0,0,1, 1,0,1,0, 7,1,1, 0,0,0,ec), $sformatf("sat%0d lw", i));
      ec = (i + 1 < 15) ? i + 1 : 15;
      apply(mk(0,0,1, 7,0,1,0, 11,1,0, 1,0,0,ec), $sformatf("sat%0d stall", i));
      apply(mk(0,0,1, 7,0,1,0, 11,1,0, 0,1,0,ec), $sformatf("sat%0d resolve", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
